// File: rtl/ram_bist_ctrl.sv
// RAM built-in self-test controller.
// Writes seed + address into every RAM word, reads each word back and
// compares it with the same pattern. Reports pass/fail, a saturating
// mismatch count and the address of the first mismatch.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the previous run held
// WRITE | one RAM write per cycle, address 0 .. DEPTH-1
// READ  | one RAM read/compare per cycle, address 0 .. DEPTH-1
// DONE  | single-cycle done pulse, pass resolved, back to IDLE
module ram_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  localparam int ERR_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  rd_mismatch;
  logic [ERR_W-1:0]      err_next;

  // Pattern word for an address: seed plus address, address zero-extended
  // or truncated to the data width, wrapping modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pattern_of(
    input logic [DATA_WIDTH-1:0] s,
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] a_ext;
    a_ext = DATA_WIDTH'(a);
    return s + a_ext;
  endfunction

  // Read-back compare against the current address; RAM read is asynchronous,
  // so mem_dout belongs to mem_addr within the same cycle.
  always_comb begin
    rd_mismatch = (mem_dout != pattern_of(seed_q, mem_addr));
    err_next    = err_count;
    if (rd_mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  // Sequencer: all RAM-facing and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seed_q    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            seed_q    <= seed;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b1;
            mem_din   <= pattern_of(seed, '0);
            busy      <= 1'b1;
            state     <= WRITE;
          end
        end

        WRITE: begin
          if (mem_addr != LAST_ADDR) begin
            mem_addr <= mem_addr + 1'b1;
            mem_din  <= pattern_of(seed_q, mem_addr + 1'b1);
          end else begin
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_din  <= '0;
            state    <= READ;
          end
        end

        READ: begin
          err_count <= err_next;
          // err_count can only be zero before the first mismatch of the run
          if (rd_mismatch && (err_count == '0)) begin
            fail_addr <= mem_addr;
          end
          if (mem_addr != LAST_ADDR) begin
            mem_addr <= mem_addr + 1'b1;
          end else begin
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (err_next == '0);
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
